// File: rtl/keccak_pkg.sv
// Shared Keccak constants, mode encodings and the squeeze sequencer state type.
package keccak_pkg;

    localparam int unsigned STATE_WIDTH   = 1600;
    localparam int unsigned RATE_SHAKE128 = 1344;
    localparam int unsigned RATE_SHAKE256 = 1088;
    localparam int unsigned w             = 64;
    localparam int unsigned w_bit_width   = 6;

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD,
        PERMUTE,
        DONE
    } squeeze_state_t;

    // Rate in bits for a mode; anything that is not SHAKE256 squeezes at the SHAKE128 rate.
    function automatic logic [31:0] rate_bits(input logic [1:0] mode);
        if (mode == SHAKE256_MODE_VEC) begin
            return 32'(RATE_SHAKE256);
        end
        return 32'(RATE_SHAKE128);
    endfunction

endpackage

// File: rtl/countern.sv
// Loadable down-counter that stops at zero; zero_c flags the expired count.
module countern #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    // Load has priority over decrement; decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/squeeze_controller.sv
// Squeeze-phase sequencer: slices the rate portion of the Keccak state into the
// dump stage one block at a time and requests permutations until the XOF length
// is produced. Optional macro SQUEEZE_BLOCK_COUNT_EN adds a blocks_emitted counter.
module squeeze_controller
    import keccak_pkg::*;
#(
    parameter int unsigned MIN_PERM_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              out_len_bits,
    input  logic [1:0]               mode_in,
    input  logic [STATE_WIDTH-1:0]   state_in,
    input  logic                     perm_done,
    input  logic                     output_buffer_empty,
    output logic                     perm_start,
    output logic [RATE_SHAKE128-1:0] output_buffer_in,
    output logic [31:0]              output_size_counter,
    output logic [1:0]               operation_mode,
    output logic                     output_buffer_we,
    output logic                     last_output_block,
    output logic                     busy,
`ifdef SQUEEZE_BLOCK_COUNT_EN
    output logic [15:0]              blocks_emitted,
`endif
    output logic                     squeeze_done
);

    localparam int unsigned GAP_W = $clog2(MIN_PERM_GAP + 1);

    squeeze_state_t state_q, state_d;

    logic [31:0]              rem_q, rem_d;
    logic [RATE_SHAKE128-1:0] buf_d;
    logic [31:0]              cnt_d;
    logic [1:0]               mode_d;
    logic                     last_d;
    logic                     we_d;
    logic                     perm_start_d;
    logic                     done_d;
    logic                     busy_d;
    logic                     gap_load;
    logic [GAP_W-1:0]         gap_count;
    logic                     gap_zero_c;
    logic [31:0]              rate_c;
    logic [RATE_SHAKE128-1:0] slice_c;
    logic                     unused_state_bits;

    // Capacity bits of the state never leave this block.
    assign unused_state_bits = ^state_in[STATE_WIDTH-1:RATE_SHAKE128];

    assign rate_c = rate_bits(operation_mode);

    // Rate slice of the state, zero-extended to the SHAKE128 buffer width.
    always_comb begin
        slice_c = state_in[RATE_SHAKE128-1:0];
        if (operation_mode == SHAKE256_MODE_VEC) begin
            slice_c[RATE_SHAKE128-1:RATE_SHAKE256] = '0;
        end
    end

    // Guard against trusting output_buffer_empty before the dump counter reloads.
    countern #(
        .WIDTH (GAP_W)
    ) u_gap_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (GAP_W'(MIN_PERM_GAP)),
        .dec        (1'b1),
        .count      (gap_count),
        .zero_c     (gap_zero_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        buf_d        = output_buffer_in;
        cnt_d        = output_size_counter;
        mode_d       = operation_mode;
        last_d       = last_output_block;
        we_d         = 1'b0;
        perm_start_d = 1'b0;
        done_d       = 1'b0;
        gap_load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode_in;
                    if (out_len_bits == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = out_len_bits;
                        state_d = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                if (output_buffer_empty && gap_zero_c) begin
                    buf_d   = slice_c;
                    cnt_d   = rem_q;
                    last_d  = (rem_q <= rate_c);
                    we_d    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gap_load = 1'b1;
                if (last_output_block) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d        = rem_q - rate_c;
                    perm_start_d = 1'b1;
                    state_d      = PERMUTE;
                end
            end
            PERMUTE: begin
                if (perm_done) begin
                    state_d = WAIT_EMPTY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered datapath and output flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q               <= '0;
            output_buffer_in    <= '0;
            output_size_counter <= '0;
            operation_mode      <= '0;
            last_output_block   <= 1'b0;
            output_buffer_we    <= 1'b0;
            perm_start          <= 1'b0;
            squeeze_done        <= 1'b0;
            busy                <= 1'b0;
        end else begin
            rem_q               <= rem_d;
            output_buffer_in    <= buf_d;
            output_size_counter <= cnt_d;
            operation_mode      <= mode_d;
            last_output_block   <= last_d;
            output_buffer_we    <= we_d;
            perm_start          <= perm_start_d;
            squeeze_done        <= done_d;
            busy                <= busy_d;
        end
    end

`ifdef SQUEEZE_BLOCK_COUNT_EN
    // Saturating count of blocks written since the last accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blocks_emitted <= '0;
        end else if ((state_q == IDLE) && start) begin
            blocks_emitted <= '0;
        end else if (we_d && (blocks_emitted != 16'hFFFF)) begin
            blocks_emitted <= blocks_emitted + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_squeeze_controller.sv
// Directed self-checking bench for squeeze_controller.
module tb_squeeze_controller;
    import keccak_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [31:0]              out_len_bits;
    logic [1:0]               mode_in;
    logic [STATE_WIDTH-1:0]   state_in;
    logic                     perm_done;
    logic                     output_buffer_empty;
    logic                     perm_start;
    logic [RATE_SHAKE128-1:0] output_buffer_in;
    logic [31:0]              output_size_counter;
    logic [1:0]               operation_mode;
    logic                     output_buffer_we;
    logic                     last_output_block;
    logic                     busy;
    logic                     squeeze_done;
`ifdef SQUEEZE_BLOCK_COUNT_EN
    logic [15:0]              blocks_emitted;
`endif

    int errors;
    int checks;

    squeeze_controller #(.MIN_PERM_GAP(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .out_len_bits        (out_len_bits),
        .mode_in             (mode_in),
        .state_in            (state_in),
        .perm_done           (perm_done),
        .output_buffer_empty (output_buffer_empty),
        .perm_start          (perm_start),
        .output_buffer_in    (output_buffer_in),
        .output_size_counter (output_size_counter),
        .operation_mode      (operation_mode),
        .output_buffer_we    (output_buffer_we),
        .last_output_block   (last_output_block),
        .busy                (busy),
`ifdef SQUEEZE_BLOCK_COUNT_EN
        .blocks_emitted      (blocks_emitted),
`endif
        .squeeze_done        (squeeze_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [STATE_WIDTH-1:0] make_state(input logic [31:0] seed);
        logic [STATE_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) begin
            s[i*64 +: 64] = {seed, 32'(i)} ^ 64'hA5A5_5A5A_0F0F_F0F0;
        end
        return s;
    endfunction

    // Issue a one-cycle start pulse; returns with the DUT in cycle 1.
    task automatic pulse_start(input logic [31:0] len, input logic [1:0] mode);
        start        = 1'b1;
        out_len_bits = len;
        mode_in      = mode;
        step();
        start        = 1'b0;
        out_len_bits = 32'd0;
        mode_in      = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || output_buffer_we !== 1'b0 || perm_start !== 1'b0 || squeeze_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b we=%b ps=%b done=%b required all 0", busy, output_buffer_we, perm_start, squeeze_done);
        end
        checks++;
        if (output_size_counter !== 32'd0 || operation_mode !== 2'b00 || last_output_block !== 1'b0 || output_buffer_in !== '0) begin
            errors++;
            $display("FAIL reset_data cnt=%0d mode=%b last=%b buf_lo=%h required all 0", output_size_counter, operation_mode, last_output_block, output_buffer_in[127:0]);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_block();
        logic [STATE_WIDTH-1:0] st;
        logic [RATE_SHAKE128-1:0] exp_buf;
        st = make_state(32'h1111_0001);
        state_in = st;
        exp_buf = st[RATE_SHAKE128-1:0];
        output_buffer_empty = 1'b1;
        pulse_start(32'd256, SHAKE128_MODE_VEC);
        checks++;
        if (busy !== 1'b1 || output_buffer_we !== 1'b0) begin
            errors++;
            $display("FAIL single_c1 busy=%b we=%b required 1 0", busy, output_buffer_we);
        end
        step();
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd256 || last_output_block !== 1'b1) begin
            errors++;
            $display("FAIL single_we we=%b cnt=%0d last=%b required 1 256 1", output_buffer_we, output_size_counter, last_output_block);
        end
        checks++;
        if (output_buffer_in !== exp_buf) begin
            errors++;
            $display("FAIL single_buf got_lo=%h required_lo=%h", output_buffer_in[127:0], exp_buf[127:0]);
        end
        step();
        checks++;
        if (squeeze_done !== 1'b1 || perm_start !== 1'b0 || output_buffer_we !== 1'b0) begin
            errors++;
            $display("FAIL single_done done=%b ps=%b we=%b required 1 0 0", squeeze_done, perm_start, output_buffer_we);
        end
        step();
        checks++;
        if (busy !== 1'b0 || squeeze_done !== 1'b0 || output_size_counter !== 32'd256) begin
            errors++;
            $display("FAIL single_idle busy=%b done=%b cnt=%0d required 0 0 256", busy, squeeze_done, output_size_counter);
        end
    endtask

    task automatic test_two_block_shake256();
        logic [STATE_WIDTH-1:0] st1, st2;
        logic [RATE_SHAKE128-1:0] exp1, exp2;
        st1 = make_state(32'h2222_0001);
        st2 = make_state(32'h2222_0002);
        exp1 = '0;
        exp1[RATE_SHAKE256-1:0] = st1[RATE_SHAKE256-1:0];
        exp2 = '0;
        exp2[RATE_SHAKE256-1:0] = st2[RATE_SHAKE256-1:0];
        state_in = st1;
        output_buffer_empty = 1'b1;
        pulse_start(32'd2176, SHAKE256_MODE_VEC);
        step();
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd2176 || last_output_block !== 1'b0 || operation_mode !== SHAKE256_MODE_VEC) begin
            errors++;
            $display("FAIL s256_we1 we=%b cnt=%0d last=%b mode=%b required 1 2176 0 01", output_buffer_we, output_size_counter, last_output_block, operation_mode);
        end
        checks++;
        if (output_buffer_in !== exp1) begin
            errors++;
            $display("FAIL s256_buf1 got_hi=%h got_lo=%h required_hi=%h", output_buffer_in[RATE_SHAKE128-1:RATE_SHAKE128-128], output_buffer_in[127:0], exp1[RATE_SHAKE128-1:RATE_SHAKE128-128]);
        end
        step();
        checks++;
        if (perm_start !== 1'b1 || output_buffer_we !== 1'b0) begin
            errors++;
            $display("FAIL s256_perm_start ps=%b we=%b required 1 0", perm_start, output_buffer_we);
        end
        perm_done = 1'b1;
        state_in = st2;
        step();
        perm_done = 1'b0;
        checks++;
        if (perm_start !== 1'b0 || output_buffer_we !== 1'b0 || output_size_counter !== 32'd2176) begin
            errors++;
            $display("FAIL s256_hold ps=%b we=%b cnt=%0d required 0 0 2176", perm_start, output_buffer_we, output_size_counter);
        end
        step();
        checks++;
        if (output_buffer_we !== 1'b0) begin
            errors++;
            $display("FAIL s256_gap_guard we=%b required 0", output_buffer_we);
        end
        step();
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd1088 || last_output_block !== 1'b1 || output_buffer_in !== exp2) begin
            errors++;
            $display("FAIL s256_we2 we=%b cnt=%0d last=%b buf_lo=%h required 1 1088 1 %h", output_buffer_we, output_size_counter, last_output_block, output_buffer_in[127:0], exp2[127:0]);
        end
        step();
        checks++;
        if (squeeze_done !== 1'b1 || perm_start !== 1'b0) begin
            errors++;
            $display("FAIL s256_done done=%b ps=%b required 1 0", squeeze_done, perm_start);
        end
        step();
    endtask

    task automatic test_zero_length();
        int we_seen;
        we_seen = 0;
        output_buffer_empty = 1'b1;
        pulse_start(32'd0, SHAKE128_MODE_VEC);
        checks++;
        if (squeeze_done !== 1'b1 || output_buffer_we !== 1'b0 || perm_start !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b we=%b ps=%b required 1 0 0", squeeze_done, output_buffer_we, perm_start);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (output_buffer_we === 1'b1 || perm_start === 1'b1) we_seen++;
        end
        checks++;
        if (we_seen !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet strobes=%0d busy=%b required 0 0", we_seen, busy);
        end
    endtask

    task automatic test_backpressure();
        int early;
        int waited;
        output_buffer_empty = 1'b1;
        state_in = make_state(32'h3333_0001);
        pulse_start(32'd3000, SHAKE128_MODE_VEC);
        step();
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd3000 || last_output_block !== 1'b0) begin
            errors++;
            $display("FAIL bp_we1 we=%b cnt=%0d last=%b required 1 3000 0", output_buffer_we, output_size_counter, last_output_block);
        end
        step();
        perm_done = 1'b1;
        output_buffer_empty = 1'b0;
        step();
        perm_done = 1'b0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (output_buffer_we === 1'b1) early++;
            step();
        end
        checks++;
        if (early !== 0 || output_size_counter !== 32'd3000) begin
            errors++;
            $display("FAIL bp_held early_we=%0d cnt=%0d required 0 3000", early, output_size_counter);
        end
        output_buffer_empty = 1'b1;
        waited = 0;
        while (output_buffer_we !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd1656 || last_output_block !== 1'b0) begin
            errors++;
            $display("FAIL bp_we2 we=%b cnt=%0d last=%b required 1 1656 0", output_buffer_we, output_size_counter, last_output_block);
        end
        step();
        checks++;
        if (perm_start !== 1'b1) begin
            errors++;
            $display("FAIL bp_perm2 ps=%b required 1", perm_start);
        end
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        waited = 0;
        while (output_buffer_we !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd312 || last_output_block !== 1'b1) begin
            errors++;
            $display("FAIL bp_we3 we=%b cnt=%0d last=%b required 1 312 1", output_buffer_we, output_size_counter, last_output_block);
        end
        step();
        checks++;
        if (squeeze_done !== 1'b1 || perm_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_done done=%b ps=%b required 1 0", squeeze_done, perm_start);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int strobes;
        int waited;
        output_buffer_empty = 1'b1;
        state_in = make_state(32'h4444_0001);
        pulse_start(32'd3000, SHAKE256_MODE_VEC);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || output_buffer_we !== 1'b0 || perm_start !== 1'b0 || squeeze_done !== 1'b0
            || output_size_counter !== 32'd0 || operation_mode !== 2'b00 || last_output_block !== 1'b0 || output_buffer_in !== '0) begin
            errors++;
            $display("FAIL midrst_clear busy=%b we=%b cnt=%0d mode=%b last=%b required all 0", busy, output_buffer_we, output_size_counter, operation_mode, last_output_block);
        end
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            if (output_buffer_we === 1'b1 || perm_start === 1'b1 || busy === 1'b1) strobes++;
            step();
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL midrst_ignore_perm_done activity=%0d required 0", strobes);
        end
        // Start while busy must be ignored.
        pulse_start(32'd3000, SHAKE128_MODE_VEC);
        step();
        step();
        pulse_start(32'd0, SHAKE256_MODE_VEC);
        checks++;
        if (operation_mode !== SHAKE128_MODE_VEC || busy !== 1'b1 || squeeze_done !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored mode=%b busy=%b done=%b required 00 1 0", operation_mode, busy, squeeze_done);
        end
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        waited = 0;
        while (output_buffer_we !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++;
        if (output_buffer_we !== 1'b1 || output_size_counter !== 32'd1656) begin
            errors++;
            $display("FAIL busy_start_continue we=%b cnt=%0d required 1 1656", output_buffer_we, output_size_counter);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

`ifdef SQUEEZE_BLOCK_COUNT_EN
    task automatic test_block_count();
        int guard;
        output_buffer_empty = 1'b1;
        pulse_start(32'd3000, SHAKE128_MODE_VEC);
        guard = 0;
        while (squeeze_done !== 1'b1 && guard < 60) begin
            perm_done = perm_start;
            step();
            guard++;
        end
        perm_done = 1'b0;
        checks++;
        if (squeeze_done !== 1'b1 || blocks_emitted !== 16'd3) begin
            errors++;
            $display("FAIL blk_count done=%b blocks=%0d required 1 3", squeeze_done, blocks_emitted);
        end
        step();
        pulse_start(32'd256, SHAKE128_MODE_VEC);
        checks++;
        if (blocks_emitted !== 16'd0) begin
            errors++;
            $display("FAIL blk_clear blocks=%0d required 0", blocks_emitted);
        end
        step();
        step();
        step();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        start = 1'b0;
        out_len_bits = 32'd0;
        mode_in = 2'b00;
        state_in = '0;
        perm_done = 1'b0;
        output_buffer_empty = 1'b1;
        test_reset();
        test_single_block();
        test_two_block_shake256();
        test_zero_length();
        test_backpressure();
        test_reset_mid_run();
`ifdef SQUEEZE_BLOCK_COUNT_EN
        test_block_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
